// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings for the SRAM responder and its bytelane helper:
//   htrans_t : IDLE / BUSY / NONSEQ / SEQ transfer types
//   hresp_t  : OKAY / ERROR responses
//   hsize_t  : byte / halfword / word transfer sizes
//   is_misaligned() : alignment test of an address against a transfer size
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERROR = 2'd1
  } hresp_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_t;

  // Sizes above a word are rejected separately, so they report aligned here.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
    logic res;
    case (size)
      SIZE_HALF: res = lsb[0];
      SIZE_WORD: res = |lsb;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ahb_sram_bytelane.sv
// ---------------------------------------------------------------------------
// ahb_sram_bytelane
// Combinational byte-lane enable for a 32-bit little-endian data bus.
// Ports:
//   size     in  3  registered HSIZE of the transfer
//   addr_lsb in  2  registered HADDR[1:0]
//   lane_en  out 4  one bit per byte lane that the transfer touches
// ---------------------------------------------------------------------------
module ahb_sram_bytelane
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lsb,
  output logic [3:0] lane_en
);

  // Decode size and low address bits into the lanes being written.
  always_comb begin
    lane_en = 4'b0000;
    case (size)
      SIZE_BYTE: lane_en = 4'b0001 << addr_lsb;
      SIZE_HALF: begin
        if (addr_lsb[1]) begin
          lane_en = 4'b1100;
        end else begin
          lane_en = 4'b0011;
        end
      end
      SIZE_WORD: lane_en = 4'b1111;
      default:   lane_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite responder backed by a DEPTH-word internal memory. Supports byte,
// halfword and word accesses, two-cycle ERROR responses for out-of-range,
// oversize or misaligned transfers, and pipelined back-to-back transfers.
//
// Build option: define AHB_SRAM_WAIT_EN to stretch every good data phase by
// WAIT_STATES o_hready-low cycles; without it every good transfer is zero-wait.
//
// Ports:
//   i_hclk    in  1        bus clock
//   i_hreset  in  1        synchronous reset, active-high
//   i_hsel    in  1        slave select
//   i_haddr   in  32       address (address phase)
//   i_htrans  in  2        transfer type
//   i_hwrite  in  1        1 = write
//   i_hsize   in  3        transfer size
//   i_hburst  in  3        burst type (ignored, beats are addressed individually)
//   i_hwdata  in  DATA_WDT write data (data phase)
//   i_hready  in  1        bus-level HREADY
//   o_hrdata  out DATA_WDT read data, zero outside a completing read
//   o_hready  out 1        slave ready
//   o_hresp   out 2        OKAY / ERROR
// ---------------------------------------------------------------------------
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef AHB_SRAM_WAIT_EN
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
`else
  localparam logic [CNT_W-1:0] WAIT_INIT = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s, take_state_s;
  logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_nxt_s, take_cnt_s;
  logic [AW-1:0]       word_addr_r;
  logic [1:0]          byte_off_r;
  logic [2:0]          size_r;
  logic                write_r;
  logic                hready_r, hready_nxt_s;
  hresp_t              hresp_r, hresp_nxt_s;
  logic                accept_s, bad_s, ack_s, commit_s;
  logic [3:0]          lane_en_s;
  logic [DATA_WDT-1:0] rdata_s;
  logic [DATA_WDT-1:0] mem_r [DEPTH];
  logic                unused_s;

  // HBURST and the BUSY/IDLE distinction carry no information for this slave.
  assign unused_s = ^{i_hburst, i_htrans[0]};

  assign accept_s = i_hsel & i_hready & i_htrans[1];
  assign bad_s    = ({2'b00, i_haddr[31:2]} >= DEPTH_W) | (i_hsize > 3'd2) |
                    is_misaligned(i_hsize, i_haddr[1:0]);
  assign ack_s    = (state_r == ST_DATA) && (wait_cnt_r == '0);
  // Reset in the same cycle drops the write that would otherwise commit.
  assign commit_s = ack_s & write_r & ~i_hreset;

  ahb_sram_bytelane u_bytelane (
    .size     (size_r),
    .addr_lsb (byte_off_r),
    .lane_en  (lane_en_s)
  );

  // Classify whatever the master presents in the address phase this cycle.
  always_comb begin
    take_state_s = ST_IDLE;
    take_cnt_s   = '0;
    if (!accept_s) begin
      take_state_s = ST_IDLE;
    end else if (bad_s) begin
      take_state_s = ST_ERR1;
    end else begin
      take_state_s = ST_DATA;
      take_cnt_s   = WAIT_INIT;
    end
  end

  // Next-state logic; a completing data or ERR2 cycle may start the next transfer.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        state_nxt_s    = take_state_s;
        wait_cnt_nxt_s = take_cnt_s;
      end
      ST_DATA: begin
        if (wait_cnt_r != '0) begin
          wait_cnt_nxt_s = wait_cnt_r - CNT_W'(1);
        end else begin
          state_nxt_s    = take_state_s;
          wait_cnt_nxt_s = take_cnt_s;
        end
      end
      ST_ERR1: begin
        state_nxt_s = ST_ERR2;
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        wait_cnt_nxt_s = '0;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave a flop.
  always_comb begin
    if (state_nxt_s == ST_ERR1) begin
      hready_nxt_s = 1'b0;
    end else if ((state_nxt_s == ST_DATA) && (wait_cnt_nxt_s != '0)) begin
      hready_nxt_s = 1'b0;
    end else begin
      hready_nxt_s = 1'b1;
    end
    if ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) begin
      hresp_nxt_s = ERROR;
    end else begin
      hresp_nxt_s = OKAY;
    end
  end

  // State, wait counter, handshake outputs and captured address-phase controls.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= '0;
      hready_r    <= 1'b1;
      hresp_r     <= OKAY;
      word_addr_r <= '0;
      byte_off_r  <= 2'b00;
      size_r      <= 3'd0;
      write_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      hready_r   <= hready_nxt_s;
      hresp_r    <= hresp_nxt_s;
      if (accept_s) begin
        word_addr_r <= i_haddr[AW+1:2];
        byte_off_r  <= i_haddr[1:0];
        size_r      <= i_hsize;
        write_r     <= i_hwrite;
      end
    end
  end

  // Memory array: contents survive reset; only enabled byte lanes change.
  always_ff @(posedge i_hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (commit_s && lane_en_s[b]) begin
        mem_r[word_addr_r][b*8 +: 8] <= i_hwdata[b*8 +: 8];
      end
    end
  end

  // Read data is presented only in the cycle a read data phase completes.
  always_comb begin
    if (ack_s && !write_r) begin
      rdata_s = mem_r[word_addr_r];
    end else begin
      rdata_s = '0;
    end
  end

  assign o_hrdata = rdata_s;
  assign o_hready = hready_r;
  assign o_hresp  = hresp_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
  import ahb_pkg::*;

`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   xfer_idx = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(
    .DATA_WDT    (32),
    .DEPTH       (1024),
    .WAIT_STATES (2)
  ) dut (
    .i_hclk   (clk),
    .i_hreset (hreset),
    .i_hsel   (hsel),
    .i_haddr  (haddr),
    .i_htrans (htrans),
    .i_hwrite (hwrite),
    .i_hsize  (hsize),
    .i_hburst (hburst),
    .i_hwdata (hwdata),
    .i_hready (hready),
    .o_hrdata (hrdata),
    .o_hready (hready),
    .o_hresp  (hresp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Drive one address phase (plus data for the previous beat) and hold it until accepted.
  task automatic cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    int n;
    hsel   = sel;
    htrans = trans;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hwdata = wdata;
    n = 0;
    @(negedge clk);
    while (!hready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!hready) begin
      checks++;
      failures++;
      $display("FAIL hready_timeout actual=%0d required=1", hready);
    end
    @(posedge clk);
    #1;
  endtask

  // Issue a selected transfer and queue the response it must produce.
  task automatic xfer(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata_prev,
                      input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
    exp_t e;
    e.rdata = exp_rdata;
    e.resp  = exp_resp;
    e.waits = (exp_resp == ERROR) ? 1 : EXP_WAITS;
    exp_q.push_back(e);
    cycle(1'b1, trans, addr, wr, size, wdata_prev);
  endtask

  task automatic idle(input logic [31:0] wdata_prev);
    cycle(1'b0, IDLE, 32'h0, 1'b0, SIZE_WORD, wdata_prev);
  endtask

  // Monitor: follows accepted address phases and scores each completing data phase.
  initial begin
    bit   dph;
    int   waits;
    exp_t e;
    dph   = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (hreset) begin
        dph   = 1'b0;
        waits = 0;
      end else begin
        if (dph) begin
          if (hready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_xfer actual=1 required=0");
            end else begin
              e = exp_q.pop_front();
              check($sformatf("x%0d_resp", xfer_idx), 32'(hresp), 32'(e.resp));
              check($sformatf("x%0d_rdata", xfer_idx), hrdata, e.rdata);
              check($sformatf("x%0d_waits", xfer_idx), 32'(waits), 32'(e.waits));
              xfer_idx++;
            end
            dph = 1'b0;
          end else begin
            waits++;
          end
        end
        if (hsel && hready && htrans[1]) begin
          dph   = 1'b1;
          waits = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset = 1'b1;
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = IDLE;
    hwrite = 1'b0;
    hsize  = SIZE_WORD;
    hburst = 3'd0;
    hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hready", 32'(hready), 32'd1);
    check("reset_hresp", 32'(hresp), 32'(OKAY));
    check("reset_hrdata", hrdata, 32'h0);
    hreset = 1'b0;

    // Word write then read back.
    xfer(NONSEQ, 32'h10, 1'b1, SIZE_WORD, 32'h0,         32'h0,         OKAY);
    xfer(NONSEQ, 32'h10, 1'b0, SIZE_WORD, 32'hDEAD_BEEF, 32'hDEAD_BEEF, OKAY);
    idle(32'h0);

    // Byte and halfword lane merges.
    xfer(NONSEQ, 32'h10, 1'b1, SIZE_WORD, 32'h0,         32'h0,         OKAY);
    xfer(NONSEQ, 32'h13, 1'b1, SIZE_BYTE, 32'h1122_3344, 32'h0,         OKAY);
    xfer(NONSEQ, 32'h10, 1'b0, SIZE_WORD, 32'hAA00_0000, 32'hAA22_3344, OKAY);
    xfer(NONSEQ, 32'h11, 1'b1, SIZE_BYTE, 32'h0,         32'h0,         OKAY);
    xfer(NONSEQ, 32'h10, 1'b0, SIZE_WORD, 32'h0000_CC00, 32'hAA22_CC44, OKAY);
    xfer(NONSEQ, 32'h14, 1'b1, SIZE_WORD, 32'h0,         32'h0,         OKAY);
    xfer(NONSEQ, 32'h16, 1'b1, SIZE_HALF, 32'h5566_7788, 32'h0,         OKAY);
    xfer(NONSEQ, 32'h14, 1'b0, SIZE_WORD, 32'hBEEF_0000, 32'hBEEF_7788, OKAY);
    idle(32'h0);

    // Back-to-back write/read with no idle gap.
    hburst = 3'd0;
    xfer(NONSEQ, 32'h20, 1'b1, SIZE_WORD, 32'h0, 32'h0, OKAY);
    xfer(NONSEQ, 32'h20, 1'b0, SIZE_WORD, 32'h5, 32'h5, OKAY);
    idle(32'h0);

    // Error responses, boundary word, and transfers that must not write.
    xfer(NONSEQ, 32'h0,         1'b1, SIZE_WORD, 32'h0,         32'h0,         OKAY);
    xfer(NONSEQ, 32'h1000,      1'b0, SIZE_WORD, 32'h0BAD_F00D, 32'h0,         ERROR);
    xfer(NONSEQ, 32'h0,         1'b0, SIZE_WORD, 32'h0,         32'h0BAD_F00D, OKAY);
    xfer(NONSEQ, 32'h2,         1'b1, SIZE_WORD, 32'h0,         32'h0,         ERROR);
    xfer(NONSEQ, 32'h1,         1'b1, SIZE_HALF, 32'hFFFF_FFFF, 32'h0,         ERROR);
    xfer(NONSEQ, 32'h0,         1'b1, 3'd3,      32'hFFFF_FFFF, 32'h0,         ERROR);
    xfer(NONSEQ, 32'h8000_0000, 1'b0, SIZE_WORD, 32'hFFFF_FFFF, 32'h0,         ERROR);
    xfer(NONSEQ, 32'hFFC,       1'b1, SIZE_WORD, 32'h0,         32'h0,         OKAY);
    xfer(NONSEQ, 32'hFFC,       1'b0, SIZE_WORD, 32'h1234_5678, 32'h1234_5678, OKAY);
    xfer(NONSEQ, 32'h0,         1'b0, SIZE_WORD, 32'h0,         32'h0BAD_F00D, OKAY);
    cycle(1'b0, NONSEQ, 32'h0, 1'b1, SIZE_WORD, 32'h0);
    cycle(1'b1, BUSY,   32'h0, 1'b1, SIZE_WORD, 32'hFFFF_FFFF);
    xfer(NONSEQ, 32'h0,         1'b0, SIZE_WORD, 32'hFFFF_FFFF, 32'h0BAD_F00D, OKAY);
    idle(32'h0);

    // Four-beat INCR write burst and read-back burst.
    hburst = 3'd3;
    for (int k = 0; k < 4; k++) begin
      xfer((k == 0) ? NONSEQ : SEQ, 32'h40 + 32'(4 * k), 1'b1, SIZE_WORD,
           (k == 0) ? 32'h0 : 32'hC0DE_0000 + 32'(k - 1), 32'h0, OKAY);
    end
    for (int k = 0; k < 4; k++) begin
      xfer((k == 0) ? NONSEQ : SEQ, 32'h40 + 32'(4 * k), 1'b0, SIZE_WORD,
           (k == 0) ? 32'hC0DE_0003 : 32'h0, 32'hC0DE_0000 + 32'(k), OKAY);
    end
    idle(32'h0);
    hburst = 3'd0;

    // Reset during a write data phase drops the write.
    xfer(NONSEQ, 32'h60, 1'b1, SIZE_WORD, 32'h0, 32'h0, OKAY);
    idle(32'h600D_600D);
    cycle(1'b1, NONSEQ, 32'h60, 1'b1, SIZE_WORD, 32'h0);
    hreset = 1'b1;
    hsel   = 1'b0;
    htrans = IDLE;
    hwdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    check("abort_hready", 32'(hready), 32'd1);
    check("abort_hresp", 32'(hresp), 32'(OKAY));
    check("abort_hrdata", hrdata, 32'h0);
    hreset = 1'b0;
    xfer(NONSEQ, 32'h60, 1'b0, SIZE_WORD, 32'h0, 32'h600D_600D, OKAY);
    idle(32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-compliant responder: the target end of transfers issued by ahb_master.
- Backs a word-addressed internal memory of DEPTH words.
- Returns OKAY/ERROR responses, supports byte/halfword/word writes and optional wait-state insertion.
- Sits on the AHB fabric as a synthesisable scratch memory and as a bench target.

Parameters:
- DATA_WDT, 32, data bus width in bits; only 32 is supported.
- DEPTH, 1024, memory size in words; power of two.
- WAIT_STATES, 0, o_hready-low cycles per data phase (used only with the optional feature).

Ports:
- i_hclk  in  1  bus clock.
- i_hreset  in  1  synchronous reset, active-high.
- i_hsel  in  1  slave select.
- i_haddr  in  32  address (address phase).
- i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hwrite  in  1  1=write.
- i_hsize  in  3  0=byte, 1=half, 2=word.
- i_hburst  in  3  burst type; not used for addressing.
- i_hwdata  in  DATA_WDT  write data (data phase).
- i_hready  in  1  bus-level HREADY (previous transfer done).
- o_hrdata  out  DATA_WDT  read data.
- o_hready  out  1  slave ready.
- o_hresp  out  2  OKAY=0, ERROR=1.

Behaviour:
- Reset: o_hready=1, o_hresp=OKAY, o_hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Reset asserted mid-transfer aborts it; any pending write is dropped.
- Address phase accepted when i_hsel & i_hready & i_htrans[1]. On acceptance, register addr, hwrite and hsize.
- Error check at acceptance:
  - ERROR if word address >= DEPTH, i_hsize>2, or the address is misaligned to i_hsize.
  - Misaligned means: half needs addr[0]=0; word needs addr[1:0]=0.
- IDLE/BUSY, or i_hsel=0, while i_hready=1: no transfer. The next cycle gives o_hready=1 and OKAY (zero-wait).
- FSM states IDLE, DATA, ERR1, ERR2:
  - IDLE -> DATA on a good accept; IDLE -> ERR1 on a bad accept.
  - DATA: o_hready=0 until the wait count expires, then o_hready=1, OKAY. Exit to DATA/ERR1/IDLE according to a new accept in the same cycle (pipelined back-to-back transfers).
  - ERR1: o_hready=0, o_hresp=ERROR. Always -> ERR2.
  - ERR2: o_hready=1, o_hresp=ERROR. A new address phase is accepted this cycle (master may have switched to IDLE), and the next state is chosen as in DATA.
- Write commit: at the clock edge ending a DATA cycle with o_hready=1. Byte lanes are taken from the registered size and addr[1:0]; unselected lanes are unchanged. ERROR transfers never write.
- Read: o_hrdata = mem[registered word addr], full word, driven while the data phase completes; 0 otherwise.
- Write then immediate read of the same address returns the new data, because the write commits before the read data phase.
- i_hburst is ignored; every beat is independently addressed. BUSY inside a burst is treated as IDLE.
- Throughput: one transfer per cycle with zero waits.

Optional Feature:
- Macro AHB_SRAM_WAIT_EN.
- Defined: each DATA phase holds o_hready=0 for exactly WAIT_STATES cycles (counter reloaded on accept), then completes. ERROR sequencing is unchanged.
- Undefined: WAIT_STATES is ignored and every good transfer is zero-wait.

Decomposition:
- Package ahb_pkg: htrans_t, hresp_t, hsize_t enums; constants OKAY, ERROR, NONSEQ, SEQ.
- Sub-module ahb_sram_bytelane: combinational lane-enable and write-mask generator from (size, addr[1:0]), 4-bit output.

Test Plan:
- Word write 0x0000_0010 <- 0xDEAD_BEEF, then read 0x10 -> o_hrdata=0xDEADBEEF, OKAY, zero waits.
- Byte write 0xAA to 0x13 over 0x11223344 -> read 0x10 returns 0xAA223344.
- Back-to-back NONSEQ write 0x20 <- 5 then read 0x20 with no IDLE gap -> returns 5, o_hready never low.
- Read address 4*DEPTH (0x1000) -> two-cycle ERROR (hready 0 then 1); next NONSEQ read at 0 accepted in ERR2 and returns OKAY.
- With AHB_SRAM_WAIT_EN and WAIT_STATES=2: 4-beat INCR write -> each beat shows exactly 2 hready-low cycles; readback matches.
- Reset asserted during a waited write -> o_hready=1, OKAY next cycle; target word keeps its old value.
